// File: rtl/n_bit_adder.sv
// n_bit_adder: pipelined N-bit adder computing sum = a + b + cin with carry-out.
// The carry chain is cut into STAGES equal segments of W = N/STAGES bits, each
// closed by a register, giving a fixed latency of STAGES cycles at full rate.
// Optional feature macro: N_BIT_ADDER_OVERFLOW_EN adds a registered signed
// overflow flag (ovf) aligned with sum/cout.
module n_bit_adder #(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid
`ifdef N_BIT_ADDER_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    // Segment width; N must be a multiple of STAGES for the segments to tile.
    localparam int W = N / STAGES;

    // Stage k adds operand bits [k*W +: W]. Each stage only carries forward the
    // operand bits that later stages still need, so the operand vector shrinks
    // by W bits per stage while the accumulated sum grows by W bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = N - k * W;

        logic [IW-1:0]        w_opA;
        logic [IW-1:0]        w_opB;
        logic                 w_cIn;
        logic                 w_vIn;
        logic [W:0]           w_seg;
        logic [(k+1)*W-1:0]   w_sumNext;
        logic [(k+1)*W-1:0]   r_sum;
        logic                 r_carry;
        logic                 r_valid;

        if (k == 0) begin : g_src
            assign w_opA     = a;
            assign w_opB     = b;
            assign w_cIn     = cin;
            assign w_vIn     = in_valid;
            assign w_sumNext = w_seg[W-1:0];
        end else begin : g_src
            assign w_opA     = g_stage[k-1].g_hi.r_aHi;
            assign w_opB     = g_stage[k-1].g_hi.r_bHi;
            assign w_cIn     = g_stage[k-1].r_carry;
            assign w_vIn     = g_stage[k-1].r_valid;
            assign w_sumNext = {w_seg[W-1:0], g_stage[k-1].r_sum};
        end

        // W-bit segment add; the extra top bit is the carry into the next segment.
        assign w_seg = {1'b0, w_opA[W-1:0]} + {1'b0, w_opB[W-1:0]} + {{W{1'b0}}, w_cIn};

        // Valid bit moves every cycle so bubbles flow through like operations.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_vIn;
            end
        end

        // Data only advances with a valid operation, so the last stage holds its result across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_vIn) begin
                r_sum   <= w_sumNext;
                r_carry <= w_seg[W];
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [IW-W-1:0] r_aHi;
            logic [IW-W-1:0] r_bHi;

            // Delay the not-yet-added upper operand bits alongside the partial sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_aHi <= '0;
                    r_bHi <= '0;
                end else if (w_vIn) begin
                    r_aHi <= w_opA[IW-1:W];
                    r_bHi <= w_opB[IW-1:W];
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign out_valid = g_stage[STAGES-1].r_valid;

`ifdef N_BIT_ADDER_OVERFLOW_EN
    logic w_aMsb;
    logic w_bMsb;
    logic w_sMsb;
    logic w_ovfNext;
    logic r_ovf;

    // The last stage sees the operand MSBs and produces the sum MSB, so the
    // signed-overflow decision is made there and registered with the sum.
    assign w_aMsb    = g_stage[STAGES-1].w_opA[W-1];
    assign w_bMsb    = g_stage[STAGES-1].w_opB[W-1];
    assign w_sMsb    = g_stage[STAGES-1].w_seg[W-1];
    assign w_ovfNext = (w_aMsb == w_bMsb) && (w_sMsb != w_aMsb);

    // Overflow flag follows the same hold-on-bubble rule as sum and cout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (g_stage[STAGES-1].w_vIn) begin
            r_ovf <= w_ovfNext;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// tb_n_bit_adder: self-checking bench for n_bit_adder. Three instances with
// STAGES = 1, 2 and 4 share one input stream; a history of applied operations
// predicts every output from plain (N+1)-bit arithmetic and the fixed latency.
// Honours N_BIT_ADDER_OVERFLOW_EN when the design is built with it.
module tb_n_bit_adder;

    localparam int N = 32;

    typedef struct {
        logic         v;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
    } opRec_t;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        logic [N-1:0] expSum;
        logic         expCout;
        logic         expOvf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;

    logic [N-1:0] sumOut [3];
    logic         coutOut [3];
    logic         validOut [3];
`ifdef N_BIT_ADDER_OVERFLOW_EN
    logic         ovfOut [3];
    logic         heldOvf [3];
`endif

    int           passChecks = 0;
    int           totalChecks = 0;
    opRec_t       hist[$];
    logic [N-1:0] heldSum [3];
    logic         heldCout [3];
    vec_t         vecs [9];

    // Instance g has STAGES = 1 << g; instance 1 is the default configuration.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        n_bit_adder #(.N(N), .STAGES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sum       (sumOut[g]),
            .cout      (coutOut[g]),
            .out_valid (validOut[g])
`ifdef N_BIT_ADDER_OVERFLOW_EN
            ,
            .ovf       (ovfOut[g])
`endif
        );
    end

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        totalChecks++;
        if (act === exp) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the op presented lat edges ago (if valid) is now on the outputs.
    task automatic checkModel();
        for (int i = 0; i < 3; i++) begin
            int           lat;
            int           idx;
            logic         expValid;
            logic [N:0]   full;
            lat = 1 << i;
            idx = hist.size() - lat;
            expValid = 1'b0;
            if (idx >= 0) begin
                if (hist[idx].v) begin
                    full = {1'b0, hist[idx].a} + {1'b0, hist[idx].b} + {{N{1'b0}}, hist[idx].c};
                    heldSum[i]  = full[N-1:0];
                    heldCout[i] = full[N];
`ifdef N_BIT_ADDER_OVERFLOW_EN
                    heldOvf[i]  = (hist[idx].a[N-1] == hist[idx].b[N-1]) && (full[N-1] != hist[idx].a[N-1]);
`endif
                    expValid = 1'b1;
                end
            end
            checkOutput($sformatf("model s%0d out_valid", lat), N'(validOut[i]), N'(expValid));
            checkOutput($sformatf("model s%0d sum", lat), sumOut[i], heldSum[i]);
            checkOutput($sformatf("model s%0d cout", lat), N'(coutOut[i]), N'(heldCout[i]));
`ifdef N_BIT_ADDER_OVERFLOW_EN
            checkOutput($sformatf("model s%0d ovf", lat), N'(ovfOut[i]), N'(heldOvf[i]));
`endif
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        opRec_t r;
        in_valid = v;
        a = x;
        b = y;
        cin = c;
        @(posedge clk);
        r.v = v;
        r.a = x;
        r.b = y;
        r.c = c;
        hist.push_back(r);
        #1;
        checkModel();
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s s%0d sum", tag, 1 << i), sumOut[i], '0);
            checkOutput($sformatf("%s s%0d cout", tag, 1 << i), N'(coutOut[i]), '0);
            checkOutput($sformatf("%s s%0d out_valid", tag, 1 << i), N'(validOut[i]), '0);
`ifdef N_BIT_ADDER_OVERFLOW_EN
            checkOutput($sformatf("%s s%0d ovf", tag, 1 << i), N'(ovfOut[i]), '0);
`endif
        end
    endtask

    task automatic clearModel();
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            heldSum[i]  = '0;
            heldCout[i] = 1'b0;
`ifdef N_BIT_ADDER_OVERFLOW_EN
            heldOvf[i]  = 1'b0;
`endif
        end
    endtask

    // Checks the default (STAGES = 2) instance against hand-computed values.
    task automatic checkMain(input string tag, input logic v, input logic [N-1:0] s, input logic c);
        checkOutput({tag, " out_valid"}, N'(validOut[1]), N'(v));
        checkOutput({tag, " sum"}, sumOut[1], s);
        checkOutput({tag, " cout"}, N'(coutOut[1]), N'(c));
    endtask

    initial begin
        vecs[0] = '{"basic 5+3",      32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{"seg carry",      32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[2] = '{"ones+0+1",       32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{"ones+ones+1",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{"sub 10-3",       32'd10,        ~32'd3,        1'b1, 32'd7,         1'b1, 1'b0};
        vecs[5] = '{"sub 3-10",       32'd3,         ~32'd10,       1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0};
        vecs[6] = '{"full ripple",    32'h0000_FFFF, 32'hFFFF_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{"pos overflow",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[8] = '{"neg overflow",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        clearModel();

        // Power-on reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // Table-driven directed vectors, one at a time through the pipeline.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].c);
            applyStimulus(1'b0, '0, '0, 1'b0);
            checkMain(vecs[i].name, 1'b1, vecs[i].expSum, vecs[i].expCout);
`ifdef N_BIT_ADDER_OVERFLOW_EN
            checkOutput({vecs[i].name, " ovf"}, N'(ovfOut[1]), N'(vecs[i].expOvf));
`endif
            repeat (2) applyStimulus(1'b0, '0, '0, 1'b0);
        end

        // Back-to-back operations with a bubble: in order, latency 2, hold on bubble.
        applyStimulus(1'b1, 32'd1, 32'd1, 1'b0);
        applyStimulus(1'b1, 32'd2, 32'd2, 1'b0);
        checkMain("tput op1", 1'b1, 32'd2, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        checkMain("tput op2", 1'b1, 32'd4, 1'b0);
        applyStimulus(1'b1, 32'd4, 32'd4, 1'b0);
        checkMain("tput bubble", 1'b0, 32'd4, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        checkMain("tput op4", 1'b1, 32'd8, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        checkMain("tput hold", 1'b0, 32'd8, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);

        // Asynchronous reset with operations in flight; nothing may emerge afterwards.
        applyStimulus(1'b1, 32'd7, 32'd7, 1'b0);
        applyStimulus(1'b1, 32'd9, 32'd9, 1'b1);
        in_valid = 1'b1;
        a = 32'd11;
        b = 32'd11;
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        clearModel();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("in reset");
        rst = 1'b0;
        repeat (6) applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        // Randomized sweep with carry-propagation corner operands mixed in.
        for (int n = 0; n < 1000; n++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            int           mode;
            x = $urandom;
            y = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) x = '1;
            if (mode == 1) y = ~x;
            applyStimulus($urandom_range(0, 3) != 0, x, y, 1'($urandom_range(0, 1)));
        end
        repeat (5) applyStimulus(1'b0, '0, '0, 1'b0);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
